// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_pkg
//  Brief    : Shared FSM state encoding and constants for the fetch stage.
//  Revision : 1.0
// ============================================================================
package if_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] c_BUBBLE = 32'h0;

endpackage
`default_nettype wire

// File: rtl/if_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : if_fifo
//  Brief    : Synchronous power-of-two FIFO with flush; push+pop legal when full.
//  Revision : 1.0
// ============================================================================
module if_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch
//  Brief    : Instruction fetch stage: req/ack memory fetch, FIFO, redirect.
//             Define IF_PERF_EN to add perf_fetch / perf_flush counters.
//  Revision : 1.0
// ============================================================================
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        id_if_pce,
    input  logic [31:0] id_if_pc,
    input  logic [31:0] id_if_off,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] is
`ifdef IF_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_flush
`endif
);

    import if_fetch_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] c_DEPTH_M1 = CW'(FIFO_DEPTH - 1);

    fetch_state_t r_state;
    fetch_state_t w_state_nx;
    logic         r_mem_req;
    logic         w_mem_req_nx;
    logic [31:0]  r_mem_addr;
    logic [31:0]  w_mem_addr_nx;
    logic [31:0]  r_fpc;
    logic [31:0]  w_fpc_nx;
    logic [31:0]  r_pc;
    logic [31:0]  r_is;
    logic [31:0]  w_target;
    logic [31:0]  w_fpc_inc;
    logic         w_accept;
    logic         w_bypass;
    logic         w_fifo_push;
    logic         w_fifo_pop;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [63:0]  w_fifo_rdata;
    logic [63:0]  w_push_word;

    assign w_target    = (id_if_pc + id_if_off) & ~32'h3;
    assign w_fpc_inc   = r_fpc + 32'd4;
    assign w_push_word = {w_fpc_inc, mem_rdata};
    assign w_accept    = (r_state == REQ) && mem_ack && !id_if_pce;
    // Empty FIFO with decode ready: hand the word straight to the output register.
    assign w_bypass    = w_accept && !stall && w_fifo_empty;
    assign w_fifo_push = w_accept && !w_bypass;
    assign w_fifo_pop  = !stall && !w_fifo_empty && !id_if_pce;

    if_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (id_if_pce),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_wdata (w_push_word),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_comb begin
        w_state_nx    = r_state;
        w_mem_req_nx  = r_mem_req;
        w_mem_addr_nx = r_mem_addr;
        w_fpc_nx      = r_fpc;
        case (r_state)
            IDLE: begin
                if (id_if_pce) begin
                    w_fpc_nx = w_target;
                end else if (!w_fifo_full) begin
                    w_mem_req_nx  = 1'b1;
                    w_mem_addr_nx = r_fpc;
                    w_state_nx    = REQ;
                end
            end
            REQ: begin
                if (id_if_pce) begin
                    w_fpc_nx = w_target;
                    if (mem_ack) begin
                        w_mem_req_nx = 1'b0;
                        w_state_nx   = IDLE;
                    end else begin
                        w_state_nx   = DROP;
                    end
                end else if (mem_ack) begin
                    w_fpc_nx = w_fpc_inc;
                    // Room is judged on the occupancy before any same-cycle pop.
                    if (w_fifo_count < c_DEPTH_M1) begin
                        w_mem_addr_nx = w_fpc_inc;
                    end else begin
                        w_mem_req_nx = 1'b0;
                        w_state_nx   = IDLE;
                    end
                end
            end
            DROP: begin
                if (id_if_pce) begin
                    w_fpc_nx = w_target;
                end
                if (mem_ack) begin
                    w_mem_req_nx = 1'b0;
                    w_state_nx   = IDLE;
                end
            end
            default: begin
                w_mem_req_nx = 1'b0;
                w_state_nx   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC;
            r_fpc      <= RESET_PC;
        end else begin
            r_state    <= w_state_nx;
            r_mem_req  <= w_mem_req_nx;
            r_mem_addr <= w_mem_addr_nx;
            r_fpc      <= w_fpc_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= 32'h0;
            r_is <= c_BUBBLE;
        end else if (id_if_pce) begin
            r_is <= c_BUBBLE;
        end else if (!stall) begin
            if (!w_fifo_empty) begin
                {r_pc, r_is} <= w_fifo_rdata;
            end else if (w_bypass) begin
                {r_pc, r_is} <= w_push_word;
            end else begin
                r_is <= c_BUBBLE;
            end
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign pc       = r_pc;
    assign is       = r_is;

`ifdef IF_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetch <= 32'h0;
            r_perf_flush <= 32'h0;
        end else begin
            if (w_accept) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (id_if_pce) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_fetch = r_perf_fetch;
    assign perf_flush = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch
//  Brief    : Self-checking bench for if_fetch against a queue-based fetch model.
//  Revision : 1.0
// ============================================================================
module tb_if_fetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        id_if_pce;
    logic [31:0] id_if_pc;
    logic [31:0] id_if_off;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] pc;
    logic [31:0] is;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_flush;
`endif

    if_fetch #(
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .id_if_pce  (id_if_pce),
        .id_if_pc   (id_if_pc),
        .id_if_off  (id_if_off),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .pc         (pc),
        .is         (is)
`ifdef IF_PERF_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_flush (perf_flush)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: in-order stream of words decode should see.
    logic [63:0] q[$];
    logic [31:0] efa;
    logic [31:0] exp_pc;
    logic [31:0] exp_is;
    bit          stale;
    bit          hold;
    logic [31:0] hold_addr;
    int          n_acc;
    int          n_flush;
    bit          rand_ack;
    int          ack_lat;
    int          wait_cnt;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hC0DE_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        q.delete();
        efa      = 32'h0;
        exp_pc   = 32'h0;
        exp_is   = 32'h0;
        stale    = 1'b0;
        hold     = 1'b0;
        n_acc    = 0;
        n_flush  = 0;
        wait_cnt = 0;
    endtask

    task automatic step();
        logic [63:0] w;
        if (!mem_req) begin
            mem_ack  = 1'b0;
        end else if (rand_ack) begin
            mem_ack = ($urandom_range(0, 2) != 0);
        end else begin
            mem_ack = (wait_cnt >= ack_lat);
        end
        mem_rdata = mem_ack ? mdata(mem_addr) : $urandom();
        if (mem_req && !mem_ack) wait_cnt++;
        else wait_cnt = 0;

        if (mem_req) chk("addr_align", {30'b0, mem_addr[1:0]}, 32'h0);
        if (hold) begin
            chk("req_hold", {31'b0, mem_req}, 32'h1);
            chk("addr_hold", mem_addr, hold_addr);
        end
        hold      = mem_req && !mem_ack;
        hold_addr = mem_addr;

        if (id_if_pce) begin
            stale  = mem_req && !mem_ack;
            efa    = (id_if_pc + id_if_off) & ~32'h3;
            q.delete();
            exp_is = 32'h0;
            n_flush++;
        end else begin
            if (mem_ack) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    chk("fetch_addr", mem_addr, efa);
                    q.push_back({efa + 32'd4, mdata(efa)});
                    efa = efa + 32'd4;
                    n_acc++;
                end
            end
            if (!stall) begin
                if (q.size() > 0) begin
                    w      = q.pop_front();
                    exp_pc = w[63:32];
                    exp_is = w[31:0];
                end else begin
                    exp_is = 32'h0;
                end
            end
        end

        @(posedge clk);
        #1;
        chk("is", is, exp_is);
        chk("pc", pc, exp_pc);
        id_if_pce = 1'b0;
    endtask

    task automatic wait_req(input int lim, input string tag);
        int n = 0;
        while (!(mem_req && !stale) && n < lim) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, {31'b0, mem_req && !stale}, 32'h1);
    endtask

    task automatic redirect(input logic [31:0] a, input logic [31:0] b);
        id_if_pce = 1'b1;
        id_if_pc  = a;
        id_if_off = b;
        step();
    endtask

    initial begin
        logic [31:0] fr_pc;
        logic [31:0] fr_is;
        logic [31:0] dropped;
        int          n;

        rst = 1'b1; stall = 1'b0; id_if_pce = 1'b0; id_if_pc = 32'h0; id_if_off = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0; rand_ack = 1'b0; ack_lat = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, mem_req}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_is", is, 32'h0);
        rst = 1'b0;

        // Sequential fetch, ack immediately, decode always ready.
        for (int i = 0; i < 12; i++) begin
            step();
            if (i >= 3) chk("b2b_no_bubble", {31'b0, is != 32'h0}, 32'h1);
        end

        // Decode stalls: FIFO fills to depth, then requests stop.
        fr_pc = pc;
        fr_is = is;
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_is", is, fr_is);
            chk("stall_pc", pc, fr_pc);
        end
        chk("stall_pushes", 32'(q.size()), 32'd4);
        chk("stall_req_off", {31'b0, mem_req}, 32'h0);
        stall = 1'b0;
        repeat (8) step();

        // Redirect while a request is waiting on ack.
        ack_lat = 3;
        wait_req(20, "t3_req");
        redirect(32'h8, 32'h100);
        chk("t3_bubble", is, 32'h0);
        wait_req(30, "t3_target");
        chk("t3_addr", mem_addr, 32'h108);
        ack_lat = 0;
        n = 0;
        while (is == 32'h0 && n < 20) begin
            step();
            n++;
        end
        chk("t3_pc", pc, 32'h10C);

        // Redirect in the same cycle as the ack.
        wait_req(20, "t4_req");
        dropped = mdata(mem_addr);
        redirect(32'h2000, 32'h0);
        wait_req(20, "t4_target");
        chk("t4_addr", mem_addr, 32'h2000);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_dropped", {31'b0, is == dropped}, 32'h0);
        end

        // Unaligned target and a slow memory.
        ack_lat = 5;
        redirect(32'h103, 32'h0);
        wait_req(30, "t5_target");
        chk("t5_addr", mem_addr, 32'h100);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_req_stable", {31'b0, mem_req}, 32'h1);
            chk("t5_addr_stable", mem_addr, 32'h100);
        end
        ack_lat = 0;
        repeat (4) step();

        // Asynchronous reset in the middle of a pending request.
        ack_lat = 5;
        wait_req(20, "t6_req");
        #3;
        rst     = 1'b1;
        mem_ack = 1'b0;
        #1;
        chk("arst_req", {31'b0, mem_req}, 32'h0);
        chk("arst_addr", mem_addr, 32'h0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_is", is, 32'h0);
        model_reset();
        @(posedge clk);
        #2;
        rst     = 1'b0;
        ack_lat = 0;

`ifdef IF_PERF_EN
        stall = 1'b1;
        for (int i = 0; i < 20 && n_acc < 3; i++) step();
        chk("perf_setup", 32'(n_acc), 32'd3);
        redirect(32'h4000, 32'h0);
        chk("perf_fetch", perf_fetch, 32'd3);
        chk("perf_flush", perf_flush, 32'd1);
        stall = 1'b0;
`endif

        // Randomized traffic: random acks, stalls and redirects.
        rand_ack = 1'b1;
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin
                id_if_pce = 1'b1;
                id_if_pc  = $urandom();
                id_if_off = $urandom();
            end
            step();
        end
`ifdef IF_PERF_EN
        chk("perf_fetch_rand", perf_fetch, 32'(n_acc));
        chk("perf_flush_rand", perf_flush, 32'(n_flush));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
